axi_reg_slice: RTL and testbench
================================

# axi_reg_slice

Parametrised five-channel AXI4 register slice inserted between an AXI master-side interface and a slave-side interface of the verification environment and DUT wrappers. It replaces direct point-to-point channel wiring with a per-channel selectable pipeline stage that breaks timing paths on valid, ready and payload. It is fully transparent in ordering and content. Each of AW, W, B, AR and R has an independent mode: bypass, full skid buffer, or light single register.

## Interface
- ID_W, 4: AXI ID width (AW/AR/B/R).
- ADDR_W, 32: address width.
- DATA_W, 64: data width; strobe width is DATA_W/8.
- USER_W, 1: width of every *user signal.
- AW_MODE, W_MODE, B_MODE, AR_MODE, R_MODE, 1 each: 0 = bypass, 1 = full (2-entry skid), 2 = light (1-entry).

Ports:
- aclk  in  1  clock; all state changes on rising edge.
- areset  in  1  reset, synchronous, active-high.
- s_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  in  ID_W/ADDR_W/8/3/2/1/4/3/4/4/USER_W  AW payload from master.
- s_awvalid in 1, s_awready out 1  AW handshake, master side.
- m_aw{...}  out  same widths  AW payload to slave; m_awvalid out 1, m_awready in 1.
- s_w{data,strb,last,user}  in  DATA_W/DATA_W/8/1/USER_W; s_wvalid in 1, s_wready out 1.
- m_w{data,strb,last,user}  out  same; m_wvalid out 1, m_wready in 1.
- m_b{id,resp,user}  in  ID_W/2/USER_W; m_bvalid in 1, m_bready out 1  (B flows slave→master).
- s_b{id,resp,user}  out  same; s_bvalid out 1, s_bready in 1.
- s_ar{...}, s_arvalid, s_arready / m_ar{...}, m_arvalid, m_arready: as AW.
- m_r{id,data,resp,last,user}  in  ID_W/DATA_W/2/1/USER_W; m_rvalid in 1, m_rready out 1.
- s_r{id,data,resp,last,user}  out  same; s_rvalid out 1, s_rready in 1.

## Operation
- One generic slice instantiated per channel; payload concatenated into one vector. "Input side" = s_ for AW/W/AR, m_ for B/R; "output side" is the other.
- Transfer occurs on a side when valid & ready are high at a rising edge. Payload must never be dropped, duplicated or reordered.
- Mode 0: output valid/payload = input valid/payload, input ready = output ready, combinational; no state.
- Mode 1 states: EMPTY, ONE, FULL (main register + skid register).
  - in_ready = (state != FULL), registered. out_valid = (state != EMPTY); output payload always from main register.
  - EMPTY + push → ONE (main loads).
  - ONE + push, no pop → FULL (skid loads). ONE + pop, no push → EMPTY. ONE + push & pop → ONE (main loads new beat).
  - FULL + pop → ONE (main ← skid). Push cannot occur in FULL.
- Mode 2: single register; in_ready = !out_valid. Push sets out_valid; pop clears it. Push and pop cannot coincide.
- Payload registers load only on push or skid move; held stable while out_valid & !out_ready (AXI stability rule).

## Timing
- Reset (areset high at an edge): all out_valid = 0, all in_ready = 0 (modes 1/2), state EMPTY, payload registers = 0. In the first cycle after areset falls, in_ready = 1. Mode 0 outputs follow inputs even during reset.
- Reset mid-burst discards buffered beats; no output valid is asserted in the cycle after the reset edge.
- Latency: mode 0, 0 cycles; modes 1 and 2, 1 cycle (beat pushed at edge N is visible at output after edge N).
- Throughput: modes 0/1, 1 beat/cycle sustained; mode 2, 1 beat per 2 cycles.
- Mode 1 with output stalled: accepts exactly 2 beats, then in_ready drops the cycle after the second push.
- No combinational path from out_ready to in_ready or in_valid to out_valid in modes 1/2.

## Test plan
- Reset: hold areset 3 cycles with all input valids high → every out_valid = 0 and in_ready = 0; one cycle after release, in_ready = 1 on all channels.
- Mode 1 streaming: W burst of 16 beats (wdata = 0..15, wlast on beat 15), m_wready = 1 → m_w sees 0..15 in order, 1 cycle delayed, no bubbles.
- Mode 1 backpressure: m_awready = 0, push AW addr 0x100, 0x200, 0x300 → first two accepted, s_awready = 0 thereafter; raise m_awready → 0x100, 0x200, 0x300 delivered in order, payload stable while stalled.
- Mode 2: R burst of 8 beats, s_rready = 1 → 8 beats delivered over 16 cycles, m_rready toggles alternately.
- Mode 0: B response id=3 resp=2'b10 → appears on s_b same cycle; s_bready = 0 gives m_bready = 0 same cycle.
- Random valid/ready on all five channels, each mode, 10k beats → scoreboard shows identical ordered content with no loss or duplication.

Source files
------------

// File: rtl/axi_reg_slice.sv
// Five-channel AXI4 register slice: each channel gets its own bypass, 2-entry skid
// or 1-entry register stage, selected by parameter.

module axi_reg_slice_stage #(
    parameter int WIDTH = 1,
    parameter int MODE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    // state | meaning
    // EMPTY | nothing buffered, main and skid free
    // ONE   | main holds the beat on the output, skid free
    // FULL  | main and skid both hold beats, input stalled
    if (MODE == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
    end else if (MODE == 1) begin : g_full
        typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
        state_t           state;
        logic [WIDTH-1:0] main_q, skid_q;
        logic             rdy_q, vld_q, push, pop;

        assign push      = in_valid & rdy_q;
        assign pop       = vld_q & out_ready;
        assign in_ready  = rdy_q;
        assign out_valid = vld_q;
        assign out_data  = main_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= EMPTY;
                main_q <= '0;
                skid_q <= '0;
                rdy_q  <= 1'b0;
                vld_q  <= 1'b0;
            end else begin
                case (state)
                    EMPTY: begin
                        rdy_q <= 1'b1;
                        if (push) begin
                            main_q <= in_data;
                            vld_q  <= 1'b1;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (push && !pop) begin
                            skid_q <= in_data;
                            rdy_q  <= 1'b0;
                            state  <= FULL;
                        end else if (pop && !push) begin
                            vld_q <= 1'b0;
                            state <= EMPTY;
                        end else if (push) begin
                            main_q <= in_data;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            main_q <= skid_q;
                            rdy_q  <= 1'b1;
                            state  <= ONE;
                        end
                    end
                    default: begin
                        rdy_q <= 1'b0;
                        vld_q <= 1'b0;
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end else begin : g_light
        logic [WIDTH-1:0] data_q;
        logic             rdy_q, vld_q;

        assign in_ready  = rdy_q;
        assign out_valid = vld_q;
        assign out_data  = data_q;

        // rdy_q tracks !vld_q but stays low through reset
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
                rdy_q  <= 1'b0;
                vld_q  <= 1'b0;
            end else if (in_valid && rdy_q) begin
                data_q <= in_data;
                vld_q  <= 1'b1;
                rdy_q  <= 1'b0;
            end else if (vld_q && out_ready) begin
                vld_q <= 1'b0;
                rdy_q <= 1'b1;
            end else begin
                rdy_q <= !vld_q;
            end
        end
    end
endmodule

module axi_reg_slice #(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int USER_W  = 1,
    parameter int AW_MODE = 1,
    parameter int W_MODE  = 1,
    parameter int B_MODE  = 1,
    parameter int AR_MODE = 1,
    parameter int R_MODE  = 1
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ID_W-1:0]     s_awid,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    input  logic                s_awlock,
    input  logic [3:0]          s_awcache,
    input  logic [2:0]          s_awprot,
    input  logic [3:0]          s_awqos,
    input  logic [3:0]          s_awregion,
    input  logic [USER_W-1:0]   s_awuser,
    input  logic                s_awvalid,
    output logic                s_awready,
    output logic [ID_W-1:0]     m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awlock,
    output logic [3:0]          m_awcache,
    output logic [2:0]          m_awprot,
    output logic [3:0]          m_awqos,
    output logic [3:0]          m_awregion,
    output logic [USER_W-1:0]   m_awuser,
    output logic                m_awvalid,
    input  logic                m_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    input  logic [USER_W-1:0]   s_wuser,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic [USER_W-1:0]   m_wuser,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    input  logic [USER_W-1:0]   m_buser,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ID_W-1:0]     s_bid,
    output logic [1:0]          s_bresp,
    output logic [USER_W-1:0]   s_buser,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    input  logic                s_arlock,
    input  logic [3:0]          s_arcache,
    input  logic [2:0]          s_arprot,
    input  logic [3:0]          s_arqos,
    input  logic [3:0]          s_arregion,
    input  logic [USER_W-1:0]   s_aruser,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_W-1:0]     m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arlock,
    output logic [3:0]          m_arcache,
    output logic [2:0]          m_arprot,
    output logic [3:0]          m_arqos,
    output logic [3:0]          m_arregion,
    output logic [USER_W-1:0]   m_aruser,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [ID_W-1:0]     m_rid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic [USER_W-1:0]   m_ruser,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ID_W-1:0]     s_rid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic [USER_W-1:0]   s_ruser,
    output logic                s_rvalid,
    input  logic                s_rready
);
    localparam int AX_PW = ID_W + ADDR_W + USER_W + 29;
    localparam int W_PW  = DATA_W + DATA_W/8 + 1 + USER_W;
    localparam int B_PW  = ID_W + 2 + USER_W;
    localparam int R_PW  = ID_W + DATA_W + 3 + USER_W;

    logic [AX_PW-1:0] aw_out, ar_out;
    logic [W_PW-1:0]  w_out;
    logic [B_PW-1:0]  b_out;
    logic [R_PW-1:0]  r_out;

    axi_reg_slice_stage #(.WIDTH(AX_PW), .MODE(AW_MODE)) u_aw (
        .clk(aclk), .rst(areset),
        .in_data({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock,
                  s_awcache, s_awprot, s_awqos, s_awregion, s_awuser}),
        .in_valid(s_awvalid), .in_ready(s_awready),
        .out_data(aw_out), .out_valid(m_awvalid), .out_ready(m_awready));
    assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock,
            m_awcache, m_awprot, m_awqos, m_awregion, m_awuser} = aw_out;

    axi_reg_slice_stage #(.WIDTH(W_PW), .MODE(W_MODE)) u_w (
        .clk(aclk), .rst(areset),
        .in_data({s_wdata, s_wstrb, s_wlast, s_wuser}),
        .in_valid(s_wvalid), .in_ready(s_wready),
        .out_data(w_out), .out_valid(m_wvalid), .out_ready(m_wready));
    assign {m_wdata, m_wstrb, m_wlast, m_wuser} = w_out;

    axi_reg_slice_stage #(.WIDTH(B_PW), .MODE(B_MODE)) u_b (
        .clk(aclk), .rst(areset),
        .in_data({m_bid, m_bresp, m_buser}),
        .in_valid(m_bvalid), .in_ready(m_bready),
        .out_data(b_out), .out_valid(s_bvalid), .out_ready(s_bready));
    assign {s_bid, s_bresp, s_buser} = b_out;

    axi_reg_slice_stage #(.WIDTH(AX_PW), .MODE(AR_MODE)) u_ar (
        .clk(aclk), .rst(areset),
        .in_data({s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock,
                  s_arcache, s_arprot, s_arqos, s_arregion, s_aruser}),
        .in_valid(s_arvalid), .in_ready(s_arready),
        .out_data(ar_out), .out_valid(m_arvalid), .out_ready(m_arready));
    assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
            m_arcache, m_arprot, m_arqos, m_arregion, m_aruser} = ar_out;

    axi_reg_slice_stage #(.WIDTH(R_PW), .MODE(R_MODE)) u_r (
        .clk(aclk), .rst(areset),
        .in_data({m_rid, m_rdata, m_rresp, m_rlast, m_ruser}),
        .in_valid(m_rvalid), .in_ready(m_rready),
        .out_data(r_out), .out_valid(s_rvalid), .out_ready(s_rready));
    assign {s_rid, s_rdata, s_rresp, s_rlast, s_ruser} = r_out;
endmodule

// File: tb/tb_axi_reg_slice.sv
// Directed and randomized checks for axi_reg_slice with AW/W/AR in skid mode,
// B in bypass and R in single-register mode.

module tb_axi_reg_slice;
    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 64, USER_W = 1;

    logic aclk = 1'b0, areset;
    always #5 aclk = ~aclk;

    logic [ID_W-1:0] s_awid, m_awid, s_arid, m_arid, m_bid, s_bid, m_rid, s_rid;
    logic [ADDR_W-1:0] s_awaddr, m_awaddr, s_araddr, m_araddr;
    logic [7:0] s_awlen, m_awlen, s_arlen, m_arlen;
    logic [2:0] s_awsize, m_awsize, s_arsize, m_arsize, s_awprot, m_awprot, s_arprot, m_arprot;
    logic [1:0] s_awburst, m_awburst, s_arburst, m_arburst;
    logic s_awlock, m_awlock, s_arlock, m_arlock;
    logic [3:0] s_awcache, m_awcache, s_arcache, m_arcache, s_awqos, m_awqos, s_arqos, m_arqos;
    logic [3:0] s_awregion, m_awregion, s_arregion, m_arregion;
    logic [USER_W-1:0] s_awuser, m_awuser, s_aruser, m_aruser, s_wuser, m_wuser;
    logic [USER_W-1:0] m_buser, s_buser, m_ruser, s_ruser;
    logic s_awvalid, s_awready, m_awvalid, m_awready, s_arvalid, s_arready, m_arvalid, m_arready;
    logic [DATA_W-1:0] s_wdata, m_wdata, m_rdata, s_rdata;
    logic [DATA_W/8-1:0] s_wstrb, m_wstrb;
    logic s_wlast, m_wlast, s_wvalid, s_wready, m_wvalid, m_wready;
    logic [1:0] m_bresp, s_bresp, m_rresp, s_rresp;
    logic m_bvalid, m_bready, s_bvalid, s_bready;
    logic m_rlast, s_rlast, m_rvalid, m_rready, s_rvalid, s_rready;

    axi_reg_slice #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .USER_W(USER_W),
                    .AW_MODE(1), .W_MODE(1), .B_MODE(0), .AR_MODE(1), .R_MODE(2)) dut (
        .aclk(aclk), .areset(areset),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_awqos(s_awqos), .s_awregion(s_awregion), .s_awuser(s_awuser),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awqos(m_awqos), .m_awregion(m_awregion), .m_awuser(m_awuser),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wuser(s_wuser),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wuser(m_wuser),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_buser(m_buser), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_buser(s_buser), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arqos(s_arqos), .s_arregion(s_arregion), .s_aruser(s_aruser),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arregion(m_arregion), .m_aruser(m_aruser),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_ruser(m_ruser),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_ruser(s_ruser),
        .s_rvalid(s_rvalid), .s_rready(s_rready));

    // per-channel views for the scoreboard: 0=AW 1=W 2=B 3=AR 4=R
    logic [127:0] in_vec [5];
    logic [127:0] out_vec[5];
    logic [4:0]   iv, ir, ov, orr;
    assign in_vec[0]  = 128'({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock,
                              s_awcache, s_awprot, s_awqos, s_awregion, s_awuser});
    assign out_vec[0] = 128'({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock,
                              m_awcache, m_awprot, m_awqos, m_awregion, m_awuser});
    assign in_vec[1]  = 128'({s_wdata, s_wstrb, s_wlast, s_wuser});
    assign out_vec[1] = 128'({m_wdata, m_wstrb, m_wlast, m_wuser});
    assign in_vec[2]  = 128'({m_bid, m_bresp, m_buser});
    assign out_vec[2] = 128'({s_bid, s_bresp, s_buser});
    assign in_vec[3]  = 128'({s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock,
                              s_arcache, s_arprot, s_arqos, s_arregion, s_aruser});
    assign out_vec[3] = 128'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
                              m_arcache, m_arprot, m_arqos, m_arregion, m_aruser});
    assign in_vec[4]  = 128'({m_rid, m_rdata, m_rresp, m_rlast, m_ruser});
    assign out_vec[4] = 128'({s_rid, s_rdata, s_rresp, s_rlast, s_ruser});
    assign iv  = {m_rvalid, s_arvalid, m_bvalid, s_wvalid, s_awvalid};
    assign ir  = {m_rready, s_arready, m_bready, s_wready, s_awready};
    assign ov  = {s_rvalid, m_arvalid, s_bvalid, m_wvalid, m_awvalid};
    assign orr = {s_rready, m_arready, s_bready, m_wready, m_awready};

    int total = 0, bad = 0;
    logic [127:0] sbq[5][$];
    logic [4:0]   hold;

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // called #1 after inputs settle: records pushes, checks pops against queue heads
    task automatic sb_eval();
        logic [127:0] e;
        for (int ch = 0; ch < 5; ch++) begin
            if (iv[ch] && ir[ch]) sbq[ch].push_back(in_vec[ch]);
            if (ov[ch] && orr[ch]) begin
                check1($sformatf("sb_nonempty_%0d", ch), sbq[ch].size() != 0, 1'b1);
                if (sbq[ch].size() != 0) begin
                    e = sbq[ch].pop_front();
                    checkv($sformatf("sb_data_%0d", ch), out_vec[ch], e);
                end
            end
            hold[ch] = iv[ch] && !ir[ch];
        end
    endtask

    initial begin
        {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot,
         s_awqos, s_awregion, s_awuser} = '0;
        {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot,
         s_arqos, s_arregion, s_aruser} = '0;
        {s_wdata, s_wstrb, s_wlast, s_wuser} = '0;
        {m_bid, m_bresp, m_buser} = '0;
        {m_rid, m_rdata, m_rresp, m_rlast, m_ruser} = '0;
        hold = '0;

        // reset with every input valid high
        areset = 1'b1;
        {s_awvalid, s_wvalid, m_bvalid, s_arvalid, m_rvalid} = 5'b11111;
        {m_awready, m_wready, s_bready, m_arready, s_rready} = 5'b11111;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check1("rst_m_awvalid", m_awvalid, 1'b0);
        check1("rst_m_wvalid", m_wvalid, 1'b0);
        check1("rst_m_arvalid", m_arvalid, 1'b0);
        check1("rst_s_rvalid", s_rvalid, 1'b0);
        check1("rst_s_awready", s_awready, 1'b0);
        check1("rst_s_wready", s_wready, 1'b0);
        check1("rst_s_arready", s_arready, 1'b0);
        check1("rst_m_rready", m_rready, 1'b0);
        check1("rst_b_bypass_valid", s_bvalid, 1'b1);
        areset = 1'b0;
        {s_awvalid, s_wvalid, m_bvalid, s_arvalid, m_rvalid} = 5'b00000;
        @(negedge aclk);
        check1("rel_s_awready", s_awready, 1'b1);
        check1("rel_s_wready", s_wready, 1'b1);
        check1("rel_s_arready", s_arready, 1'b1);
        check1("rel_m_rready", m_rready, 1'b1);
        check1("rel_m_awvalid", m_awvalid, 1'b0);

        // mode 1 streaming: 16-beat W burst, one cycle latency, no bubbles
        for (int i = 0; i <= 16; i++) begin
            @(negedge aclk);
            if (i > 0) begin
                check1("w_stream_valid", m_wvalid, 1'b1);
                checkv("w_stream_data", 128'(m_wdata), 128'(i - 1));
                check1("w_stream_last", m_wlast, (i == 16));
            end
            if (i < 16) begin
                s_wvalid = 1'b1;
                s_wdata  = 64'(i);
                s_wstrb  = 8'hff;
                s_wlast  = (i == 15);
                #1 check1("w_stream_ready", s_wready, 1'b1);
            end else begin
                s_wvalid = 1'b0;
            end
        end
        @(negedge aclk);
        check1("w_stream_idle", m_wvalid, 1'b0);

        // mode 1 backpressure on AW
        m_awready = 1'b0;
        s_awvalid = 1'b1;
        s_awaddr  = 32'h100;
        #1 check1("aw_bp_rdy0", s_awready, 1'b1);
        @(negedge aclk);
        check1("aw_bp_rdy1", s_awready, 1'b1);
        checkv("aw_bp_out0", 128'(m_awaddr), 128'(32'h100));
        s_awaddr = 32'h200;
        @(negedge aclk);
        check1("aw_bp_full", s_awready, 1'b0);
        s_awaddr = 32'h300;
        repeat (2) begin
            @(negedge aclk);
            check1("aw_bp_stall_rdy", s_awready, 1'b0);
            check1("aw_bp_stall_vld", m_awvalid, 1'b1);
            checkv("aw_bp_stable", 128'(m_awaddr), 128'(32'h100));
        end
        m_awready = 1'b1;
        @(negedge aclk);
        checkv("aw_bp_out1", 128'(m_awaddr), 128'(32'h200));
        check1("aw_bp_reopen", s_awready, 1'b1);
        @(negedge aclk);
        s_awvalid = 1'b0;
        checkv("aw_bp_out2", 128'(m_awaddr), 128'(32'h300));
        check1("aw_bp_vld2", m_awvalid, 1'b1);
        @(negedge aclk);
        check1("aw_bp_drained", m_awvalid, 1'b0);

        // reset while a beat is buffered
        m_awready = 1'b0;
        s_awvalid = 1'b1;
        s_awaddr  = 32'h400;
        @(negedge aclk);
        check1("mid_rst_pre", m_awvalid, 1'b1);
        s_awvalid = 1'b0;
        areset    = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        check1("mid_rst_vld", m_awvalid, 1'b0);
        check1("mid_rst_rdy", s_awready, 1'b0);
        checkv("mid_rst_payload", 128'(m_awaddr), 128'(0));
        @(negedge aclk);
        check1("mid_rst_vld2", m_awvalid, 1'b0);
        check1("mid_rst_rdy2", s_awready, 1'b1);
        m_awready = 1'b1;

        // mode 0 B: same-cycle pass-through both directions
        m_bvalid = 1'b1;
        m_bid    = 4'd3;
        m_bresp  = 2'b10;
        s_bready = 1'b0;
        #1;
        check1("b_valid", s_bvalid, 1'b1);
        checkv("b_id", 128'(s_bid), 128'(4'd3));
        checkv("b_resp", 128'(s_bresp), 128'(2'b10));
        check1("b_ready_lo", m_bready, 1'b0);
        s_bready = 1'b1;
        #1 check1("b_ready_hi", m_bready, 1'b1);
        @(negedge aclk);
        m_bvalid = 1'b0;

        // mode 2 R: 8 beats over 16 cycles, m_rready alternating
        begin
            int pushed = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge aclk);
                m_rvalid = (pushed < 8);
                m_rdata  = 64'(pushed);
                m_rlast  = (pushed == 7);
                #1;
                check1("r_ready_alt", m_rready, (c % 2 == 0));
                check1("r_valid_alt", s_rvalid, (c % 2 == 1));
                if (c % 2 == 1) checkv("r_data", 128'(s_rdata), 128'(c / 2));
                if (m_rvalid && m_rready) pushed++;
            end
            @(negedge aclk);
            m_rvalid = 1'b0;
            check1("r_done", s_rvalid, 1'b0);
            checkv("r_pushed", 128'(pushed), 128'(8));
        end

        // random valid/ready on all channels against a FIFO scoreboard
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge aclk);
            if (!hold[0]) begin
                s_awvalid = 1'($urandom_range(0, 1));
                s_awid = 4'($urandom); s_awaddr = $urandom; s_awlen = 8'($urandom);
                s_awprot = 3'($urandom); s_awuser = 1'($urandom);
            end
            if (!hold[1]) begin
                s_wvalid = 1'($urandom_range(0, 1));
                s_wdata = {$urandom, $urandom}; s_wstrb = 8'($urandom);
                s_wlast = 1'($urandom); s_wuser = 1'($urandom);
            end
            if (!hold[2]) begin
                m_bvalid = 1'($urandom_range(0, 1));
                m_bid = 4'($urandom); m_bresp = 2'($urandom); m_buser = 1'($urandom);
            end
            if (!hold[3]) begin
                s_arvalid = 1'($urandom_range(0, 1));
                s_arid = 4'($urandom); s_araddr = $urandom; s_arlen = 8'($urandom);
                s_arcache = 4'($urandom); s_aruser = 1'($urandom);
            end
            if (!hold[4]) begin
                m_rvalid = 1'($urandom_range(0, 1));
                m_rid = 4'($urandom); m_rdata = {$urandom, $urandom};
                m_rresp = 2'($urandom); m_rlast = 1'($urandom); m_ruser = 1'($urandom);
            end
            {m_awready, m_wready, s_bready, m_arready, s_rready} = 5'($urandom);
            #1 sb_eval();
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge aclk);
            if (!hold[0]) s_awvalid = 1'b0;
            if (!hold[1]) s_wvalid = 1'b0;
            if (!hold[2]) m_bvalid = 1'b0;
            if (!hold[3]) s_arvalid = 1'b0;
            if (!hold[4]) m_rvalid = 1'b0;
            {m_awready, m_wready, s_bready, m_arready, s_rready} = 5'b11111;
            #1 sb_eval();
        end
        for (int ch = 0; ch < 5; ch++)
            checkv($sformatf("sb_empty_%0d", ch), 128'(sbq[ch].size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
